// File: rtl/answer_judge.sv
// Judge stage of the factorization game: checks that three submitted digits are
// primes whose product is the target, then holds a verdict and keeps a wrapping score.
module answer_judge #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int HOLD_W      = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SUBMIT_IN,
  input  logic [3:0] F1_IN,
  input  logic [3:0] F2_IN,
  input  logic [3:0] F3_IN,
  input  logic [9:0] TARGET_IN,
  output logic [1:0] RESULT_OUT,
  output logic       BUSY_OUT,
  output logic [3:0] SCORE_OUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPT, S_MUL1, S_MUL2, S_CHECK, S_SHOW
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] ONE     = HOLD_W'(1);

  state_t            r_state, w_next;
  logic              r_sub_q;
  logic [3:0]        r_f1, r_f2, r_f3;
  logic [9:0]        r_target;
  logic [13:0]       r_prod;
  logic [HOLD_W-1:0] r_timer;
  logic [1:0]        r_result;
  logic [3:0]        r_score;
  logic              r_busy;

  logic              w_start;
  logic [7:0]        w_mul1;
  logic [13:0]       w_mul2;
  logic              w_ok;

  function automatic logic is_prime(input logic [3:0] d);
    return (d == 4'd2) || (d == 4'd3) || (d == 4'd5) || (d == 4'd7);
  endfunction

  assign w_start = SUBMIT_IN & ~r_sub_q;
  assign w_mul1  = {4'd0, r_f1} * {4'd0, r_f2};
  // Full 14-bit product so out-of-range digits can never alias onto a valid target.
  assign w_mul2  = r_prod * {10'd0, r_f3};
  assign w_ok    = is_prime(r_f1) && is_prime(r_f2) && is_prime(r_f3) &&
                   (r_prod == {4'd0, r_target});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_CAPT;
      S_CAPT:  w_next = S_MUL1;
      S_MUL1:  w_next = S_MUL2;
      S_MUL2:  w_next = S_CHECK;
      S_CHECK: w_next = S_SHOW;
      S_SHOW:  if (r_timer == ONE) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sub_q  <= 1'b0;
      r_f1     <= '0;
      r_f2     <= '0;
      r_f3     <= '0;
      r_target <= '0;
      r_prod   <= '0;
      r_timer  <= '0;
      r_result <= 2'b00;
      r_score  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_sub_q <= SUBMIT_IN;
      r_busy  <= (w_next != S_IDLE);
      case (r_state)
        S_CAPT: begin
          // Entry-stage digits become valid one cycle after the submit edge.
          r_f1     <= F1_IN;
          r_f2     <= F2_IN;
          r_f3     <= F3_IN;
          r_target <= TARGET_IN;
        end
        S_MUL1: r_prod <= {6'd0, w_mul1};
        S_MUL2: r_prod <= w_mul2;
        S_CHECK: begin
          r_timer <= HOLD_LD;
          if (w_ok) begin
            r_result <= 2'b11;
            r_score  <= (r_score == 4'd9) ? 4'd0 : r_score + 4'd1;
          end else begin
            r_result <= 2'b01;
          end
        end
        S_SHOW: begin
          r_timer <= r_timer - ONE;
          if (r_timer == ONE) r_result <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign RESULT_OUT = r_result;
  assign BUSY_OUT   = r_busy;
  assign SCORE_OUT  = r_score;

endmodule
